// File: rtl/irq_ctrl.sv
// Machine-level interrupt controller: sticky timer/sw pending, synchronized ext level,
// fixed priority (ext > sw > timer) and a req/ack/mret handshake toward the pipeline.
module irq_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             timer_interrupt,
  input  logic             sw_irq,
  input  logic             ext_irq,
  input  logic             global_ie,
  input  logic [2:0]       mie,
  input  logic             irq_ack,
  input  logic             mret,
  output logic             irq_req,
  output logic [31:0]      irq_cause,
  output logic [2:0]       pending,
  output logic             in_handler,
  output logic [CNT_W-1:0] missed_timer
);

  localparam logic [31:0] CAUSE_EXT = 32'h8000_000B;
  localparam logic [31:0] CAUSE_SW  = 32'h8000_0003;
  localparam logic [31:0] CAUSE_TIM = 32'h8000_0007;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HANDLER} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   p_tim_q, p_tim_d;
  logic                   p_sw_q, p_sw_d;
  logic [CNT_W-1:0]       missed_q, missed_d;
  logic [2:0]             src_q, src_d;
  logic [31:0]            cause_q, cause_d;
  logic                   req_q, req_d;
  logic                   inh_q, inh_d;

  logic [2:0]  pend, act, sel;
  logic [31:0] sel_cause;
  logic        elig, hs, clr_tim, clr_sw;

  assign pend    = {sync_q[SYNC_STAGES-1], p_sw_q, p_tim_q};
  assign act     = pend & mie;
  assign elig    = global_ie && (|act);
  assign hs      = req_q && irq_ack;
  assign clr_tim = hs && src_q[0];
  assign clr_sw  = hs && src_q[1];

  always_comb begin
    sel       = 3'b001;
    sel_cause = CAUSE_TIM;
    if (act[2]) begin
      sel       = 3'b100;
      sel_cause = CAUSE_EXT;
    end else if (act[1]) begin
      sel       = 3'b010;
      sel_cause = CAUSE_SW;
    end
  end

  // A new pulse in the same cycle as the clear wins; a pulse on an already
  // pending timer that is not being serviced this cycle counts as lost.
  always_comb begin
    p_tim_d  = timer_interrupt | (p_tim_q & ~clr_tim);
    p_sw_d   = sw_irq | (p_sw_q & ~clr_sw);
    missed_d = missed_q;
    if (timer_interrupt && p_tim_q && !clr_tim && (missed_q != {CNT_W{1'b1}}))
      missed_d = missed_q + CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    cause_d = 32'h0;
    req_d   = 1'b0;
    inh_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        src_d = 3'b000;
        if (elig) begin
          state_d = S_REQ;
          src_d   = sel;
          cause_d = sel_cause;
          req_d   = 1'b1;
        end
      end
      S_REQ: begin
        // Ack beats a same-cycle withdraw: the pipeline already saw irq_req=1.
        if (irq_ack) begin
          state_d = S_HANDLER;
          inh_d   = 1'b1;
        end else if (!elig || !(|(act & src_q))) begin
          state_d = S_IDLE;
        end else begin
          cause_d = cause_q;
          req_d   = 1'b1;
        end
      end
      S_HANDLER: begin
        if (mret) state_d = S_IDLE;
        else      inh_d   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sync_q   <= '0;
      p_tim_q  <= 1'b0;
      p_sw_q   <= 1'b0;
      missed_q <= '0;
      src_q    <= 3'b000;
      cause_q  <= 32'h0;
      req_q    <= 1'b0;
      inh_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], ext_irq};
      p_tim_q  <= p_tim_d;
      p_sw_q   <= p_sw_d;
      missed_q <= missed_d;
      src_q    <= src_d;
      cause_q  <= cause_d;
      req_q    <= req_d;
      inh_q    <= inh_d;
    end
  end

  assign irq_req      = req_q;
  assign irq_cause    = cause_q;
  assign pending      = pend;
  assign in_handler   = inh_q;
  assign missed_timer = missed_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: timer path, priority, withdraw, set/clear collision,
// missed-counter saturation and asynchronous reset.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        timer_interrupt, sw_irq, ext_irq, global_ie, irq_ack, mret;
  logic [2:0]  mie;
  logic        irq_req, in_handler;
  logic [31:0] irq_cause;
  logic [2:0]  pending;
  logic [7:0]  missed_timer;

  int errs   = 0;
  int checks = 0;

  irq_ctrl #(.SYNC_STAGES(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .timer_interrupt(timer_interrupt), .sw_irq(sw_irq),
    .ext_irq(ext_irq), .global_ie(global_ie), .mie(mie), .irq_ack(irq_ack),
    .mret(mret), .irq_req(irq_req), .irq_cause(irq_cause), .pending(pending),
    .in_handler(in_handler), .missed_timer(missed_timer)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1ns after it, pulses are then dropped.
  task automatic step();
    @(posedge clk);
    #1;
    timer_interrupt = 1'b0;
    sw_irq          = 1'b0;
    irq_ack         = 1'b0;
    mret            = 1'b0;
  endtask

  task automatic ack_and_ret();
    irq_ack = 1'b1; step();
    mret    = 1'b1; step();
  endtask

  initial begin
    rst = 1'b1;
    timer_interrupt = 0; sw_irq = 0; ext_irq = 0; global_ie = 0;
    irq_ack = 0; mret = 0; mie = 3'b000;
    #12;
    check("rst_req", irq_req, 0);
    check("rst_cause", irq_cause, 0);
    check("rst_pend", pending, 0);
    check("rst_inh", in_handler, 0);
    check("rst_missed", missed_timer, 0);
    @(negedge clk); rst = 1'b0;
    step(); step();

    // Timer path
    mie = 3'b001; global_ie = 1'b1;
    timer_interrupt = 1'b1; step();
    check("tim_pend", pending, 3'b001);
    check("tim_req_early", irq_req, 0);
    step();
    check("tim_req", irq_req, 1);
    check("tim_cause", irq_cause, 32'h8000_0007);
    step();
    check("tim_hold", irq_cause, 32'h8000_0007);
    irq_ack = 1'b1; step();
    check("tim_ack_pend", pending, 0);
    check("tim_ack_inh", in_handler, 1);
    check("tim_ack_req", irq_req, 0);
    check("tim_ack_cause", irq_cause, 0);
    irq_ack = 1'b1; step();
    check("ack_ignored", in_handler, 1);
    step(); step();
    mret = 1'b1; step();
    check("tim_mret_inh", in_handler, 0);
    step();
    check("tim_idle_req", irq_req, 0);

    // Priority ext > sw > timer
    mie = 3'b111;
    ext_irq = 1'b1; step();
    timer_interrupt = 1'b1; sw_irq = 1'b1; step();
    check("pri_pend", pending, 3'b111);
    step();
    check("pri_c1", irq_cause, 32'h8000_000B);
    irq_ack = 1'b1; step();
    check("pri_h1_pend", pending, 3'b111);
    check("pri_h1_inh", in_handler, 1);
    ext_irq = 1'b0; step(); step();
    check("pri_ext_drop", pending, 3'b011);
    mret = 1'b1; step();
    check("pri_idle", irq_req, 0);
    step();
    check("pri_c2", irq_cause, 32'h8000_0003);
    irq_ack = 1'b1; step();
    check("pri_h2_pend", pending, 3'b001);
    mret = 1'b1; step(); step();
    check("pri_c3", irq_cause, 32'h8000_0007);
    ack_and_ret();
    check("pri_done", pending, 0);

    // Withdraw by disabling the timer before ack
    mie = 3'b001;
    timer_interrupt = 1'b1; step(); step();
    check("wd_req", irq_req, 1);
    mie = 3'b000; step();
    check("wd_req_fall", irq_req, 0);
    check("wd_cause", irq_cause, 0);
    check("wd_pend", pending, 3'b001);
    irq_ack = 1'b1; step();
    check("wd_stray_ack", in_handler, 0);
    mie = 3'b001; step();
    check("wd_rereq", irq_req, 1);
    check("wd_recause", irq_cause, 32'h8000_0007);
    ack_and_ret();

    // Set/clear collision on the timer bit
    timer_interrupt = 1'b1; step(); step();
    check("col_req", irq_req, 1);
    irq_ack = 1'b1; timer_interrupt = 1'b1; step();
    check("col_inh", in_handler, 1);
    check("col_pend", pending, 3'b001);
    check("col_missed", missed_timer, 0);
    mret = 1'b1; step();
    check("col_mret", in_handler, 0);
    step();
    check("col_req2", irq_req, 1);
    check("col_cause2", irq_cause, 32'h8000_0007);
    ack_and_ret();

    // Missed counter saturation with interrupts globally disabled
    global_ie = 1'b0;
    begin
      int bad = 0;
      for (int i = 0; i < 300; i++) begin
        timer_interrupt = 1'b1; step();
        if (irq_req !== 1'b0) bad++;
      end
      check("miss_noreq", bad, 0);
    end
    check("miss_sat", missed_timer, 8'd255);
    check("miss_pend", pending, 3'b001);
    global_ie = 1'b1; step();
    check("miss_req", irq_req, 1);
    ack_and_ret();
    check("miss_keep", missed_timer, 8'd255);

    // Asynchronous reset while in HANDLER with timer+sw pending
    mie = 3'b011;
    timer_interrupt = 1'b1; step(); step();
    irq_ack = 1'b1; step();
    timer_interrupt = 1'b1; sw_irq = 1'b1; step();
    check("rs_inh", in_handler, 1);
    check("rs_pend", pending, 3'b011);
    #2 rst = 1'b1;
    #1;
    check("rs_req", irq_req, 0);
    check("rs_cause", irq_cause, 0);
    check("rs_pend0", pending, 0);
    check("rs_inh0", in_handler, 0);
    check("rs_missed0", missed_timer, 0);
    @(negedge clk); rst = 1'b0;
    step(); step(); step();
    check("rs_quiet", irq_req, 0);
    timer_interrupt = 1'b1; step(); step();
    check("rs_new_req", irq_req, 1);
    check("rs_new_cause", irq_cause, 32'h8000_0007);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Machine-level interrupt controller sitting directly downstream of `timer`, between the interrupt sources and the CSR/trap logic of the pipeline. It latches the single-cycle `timer_interrupt` pulse, together with a software-interrupt pulse and a synchronized external level, into sticky pending bits. It applies the enable masks and fixed priority, then presents one interrupt request with a stable cause code to the pipeline under a request/acknowledge handshake. It also tracks handler occupancy until `mret`.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: flop stages on `ext_irq`; legal values are 2 or 3.
- `CNT_W`, default 8: width of the saturating missed-timer counter.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `timer_interrupt`, input, 1: one-cycle pulse from `timer`.
- `sw_irq`, input, 1: one-cycle pulse that sets software-interrupt pending.
- `ext_irq`, input, 1: asynchronous level from the external source.
- `global_ie`, input, 1: mstatus.MIE.
- `mie`, input, 3: per-source enables as {MEIE, MSIE, MTIE}, i.e. bit2 = ext, bit1 = sw, bit0 = timer.
- `irq_ack`, input, 1: pipeline accepts the request (trap taken).
- `mret`, input, 1: one-cycle pulse on `mret` retire.
- `irq_req`, output, 1: interrupt request to the pipeline.
- `irq_cause`, output, 32: mcause value, valid while `irq_req`=1.
- `pending`, output, 3: mip view, in the same bit order as `mie`.
- `in_handler`, output, 1: a trap has been accepted and is not yet returned.
- `missed_timer`, output, CNT_W: count of timer pulses lost.

## Operation

Pending bits:
- p_tim is set by `timer_interrupt`. It is cleared on the handshake (`irq_req`&&`irq_ack`) only when the latched cause is timer. If a set and a clear land in the same cycle, set wins.
- p_sw behaves like p_tim, driven by `sw_irq`.
- p_ext is not sticky: it equals the synchronizer output and is never cleared by ack.
- `missed_timer` increments when `timer_interrupt`=1 while p_tim=1 and p_tim is not being cleared that cycle. It saturates at 2^CNT_W−1 and is cleared only by reset.

Eligibility and priority:
- `elig` = `global_ie` && |(`pending` & `mie`).
- Priority is ext > sw > timer.
- Causes: ext = 0x8000000B, sw = 0x80000003, timer = 0x80000007.

FSM states are IDLE, REQ and HANDLER:
- IDLE → REQ when `elig`=1. On entry, latch the highest-priority enabled pending source into `irq_cause`.
- In REQ, `irq_req`=1 and `irq_cause` stays frozen. A higher-priority source arriving later does not replace it.
- REQ → HANDLER on `irq_ack`=1. This clears the matching sticky bit.
- REQ → IDLE when `elig` drops, or when the latched source's pending or enable bit drops before ack (withdraw). `irq_req` then falls in the next cycle.
- HANDLER → IDLE on `mret`. No nesting: pending sources accumulate while in HANDLER.
- `mret` outside HANDLER is ignored. `irq_ack` outside REQ is ignored.

Outputs by state:
- `in_handler`=1 exactly in HANDLER.
- `irq_cause` reads 0 outside REQ.

## Timing

- All outputs are registered.
- Reset values: `irq_req`=0, `irq_cause`=0, `pending`=0, `in_handler`=0, `missed_timer`=0, FSM=IDLE, synchronizer flops=0.
- `timer_interrupt` at edge N sets p_tim, visible at N+1. With enables on, `irq_req` rises at N+2.
- `ext_irq` rising before edge N gives p_ext=1 after SYNC_STAGES edges. `irq_req` rises one edge later.
- For an ack sampled at edge M: `irq_req`=0 and `in_handler`=1 after M. The pending clear is also visible after M.
- For `mret` at edge K: `in_handler`=0 after K. If `elig` still holds, `irq_req` is reasserted after K+1. There is a minimum of one IDLE cycle.
- For `mret` and a new pulse in the same cycle, the new pulse is latched and serviced after IDLE.
- An `rst` assertion at any point, including REQ or HANDLER, returns every output to its reset value immediately, without waiting for a clock edge.

## Test plan

- Timer path: `mie`=3'b001, `global_ie`=1, pulse `timer_interrupt` at cycle 10.
  - `pending`=3'b001 at 11.
  - `irq_req`=1 with `irq_cause`=0x80000007 at 12.
  - Ack at 14 → `pending`=0 and `in_handler`=1.
  - `mret` at 20 → `in_handler`=0.
- Priority: with all enables set, assert sw and timer pulses and hold `ext_irq` high simultaneously.
  - The first cause is 0x8000000B; after its `mret`, the next is 0x80000003, then 0x80000007.
  - p_ext stays set while `ext_irq` is high.
- Withdraw: in REQ for timer, drop `mie`[0] before ack.
  - `irq_req` falls the next cycle and the FSM returns to IDLE.
  - p_tim stays 1; re-enabling re-requests with 0x80000007.
- Missed counter: send 300 timer pulses with `global_ie`=0.
  - `missed_timer`=255, saturated, with `CNT_W`=8.
  - p_tim=1, and `irq_req` stays 0 throughout.
- Set/clear collision: a timer pulse in the same cycle as the ack of a timer cause.
  - After that edge, `in_handler`=1 and p_tim=1.
  - `missed_timer` is unchanged.
  - After `mret`, a second timer request appears.
- Reset mid-operation: assert `rst` in HANDLER with `pending`=3'b011.
  - All outputs are 0 before the next clock edge.
  - After release, no request appears until a new event.
